// File: rtl/cache_controller.sv
// Two-level write-through cache controller (direct-mapped L1 16 words, L2 64 words)
// in front of a 256-word on-chip memory; one request at a time, fixed lookup latencies.
module cache_controller #(
   parameter int WORD_SIZE = 32,
   parameter int L1_DELAY  = 3,
   parameter int L2_DELAY  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [WORD_SIZE-1:0] addr,
   input  logic [WORD_SIZE-1:0] data,
   output logic [WORD_SIZE-1:0] data_out
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_L1_LOOK = 3'd1;
   localparam logic [2:0] S_L2_LOOK = 3'd2;
   localparam logic [2:0] S_MEM_RD  = 3'd3;
   localparam logic [2:0] S_WRITE   = 3'd4;

   localparam logic [7:0] L1_LAST = 8'(L1_DELAY);
   localparam logic [7:0] L2_LAST = 8'(L2_DELAY);

   logic [2:0]           r_state;
   logic [7:0]           r_cnt;
   logic [7:0]           r_addr;
   logic [WORD_SIZE-1:0] r_data;
   logic [WORD_SIZE-1:0] r_dataOut;

   logic [15:0]          r_l1Valid;
   logic [3:0]           r_l1Tag  [16];
   logic [WORD_SIZE-1:0] r_l1Data [16];
   logic [63:0]          r_l2Valid;
   logic [1:0]           r_l2Tag  [64];
   logic [WORD_SIZE-1:0] r_l2Data [64];
   logic [WORD_SIZE-1:0] r_mem    [256];

   logic [3:0] w_l1Idx;
   logic [5:0] w_l2Idx;
   logic       w_l1Hit;
   logic       w_l2Hit;
   logic       w_unusedAddr;

   // Only the low address byte selects storage; everything above aliases.
   assign w_unusedAddr = ^addr[WORD_SIZE-1:8];
   assign w_l1Idx      = r_addr[3:0];
   assign w_l2Idx      = r_addr[5:0];
   assign w_l1Hit      = r_l1Valid[w_l1Idx] && (r_l1Tag[w_l1Idx] == r_addr[7:4]);
   assign w_l2Hit      = r_l2Valid[w_l2Idx] && (r_l2Tag[w_l2Idx] == r_addr[7:6]);
   assign data_out     = r_dataOut;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_data    <= '0;
         r_dataOut <= '0;
         r_l1Valid <= '0;
         r_l2Valid <= '0;
         for (int i = 0; i < 16; i++) begin
            r_l1Tag[i]  <= '0;
            r_l1Data[i] <= '0;
         end
         for (int i = 0; i < 64; i++) begin
            r_l2Tag[i]  <= '0;
            r_l2Data[i] <= '0;
         end
         for (int i = 0; i < 256; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               r_addr  <= addr[7:0];
               r_data  <= data;
               r_cnt   <= 8'd1;
               r_state <= wr_en ? S_WRITE : S_L1_LOOK;
            end
            S_L1_LOOK: begin
               if (r_cnt == L1_LAST) begin
                  if (w_l1Hit) begin
                     r_dataOut <= r_l1Data[w_l1Idx];
                     r_state   <= S_IDLE;
                  end else begin
                     r_cnt   <= 8'd1;
                     r_state <= S_L2_LOOK;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_L2_LOOK: begin
               if (r_cnt == L2_LAST) begin
                  if (w_l2Hit) begin
                     r_dataOut          <= r_l2Data[w_l2Idx];
                     r_l1Valid[w_l1Idx] <= 1'b1;
                     r_l1Tag[w_l1Idx]   <= r_addr[7:4];
                     r_l1Data[w_l1Idx]  <= r_l2Data[w_l2Idx];
                     r_state            <= S_IDLE;
                  end else begin
                     r_state <= S_MEM_RD;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_MEM_RD: begin
               r_dataOut          <= r_mem[r_addr];
               r_l2Valid[w_l2Idx] <= 1'b1;
               r_l2Tag[w_l2Idx]   <= r_addr[7:6];
               r_l2Data[w_l2Idx]  <= r_mem[r_addr];
               r_l1Valid[w_l1Idx] <= 1'b1;
               r_l1Tag[w_l1Idx]   <= r_addr[7:4];
               r_l1Data[w_l1Idx]  <= r_mem[r_addr];
               r_state            <= S_IDLE;
            end
            S_WRITE: begin
               // Write-through with allocate: all three levels take the word together.
               if (r_cnt == L1_LAST) begin
                  r_mem[r_addr]      <= r_data;
                  r_l2Valid[w_l2Idx] <= 1'b1;
                  r_l2Tag[w_l2Idx]   <= r_addr[7:6];
                  r_l2Data[w_l2Idx]  <= r_data;
                  r_l1Valid[w_l1Idx] <= 1'b1;
                  r_l1Tag[w_l1Idx]   <= r_addr[7:4];
                  r_l1Data[w_l1Idx]  <= r_data;
                  r_state            <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_controller.sv
// Directed testbench for cache_controller: a table of read/write requests with
// hand-computed results and latencies, plus a mid-operation reset sequence.
module tb_cache_controller;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [31:0] addr;
   logic [31:0] data;
   logic [31:0] data_out;

   int total;
   int bad;
   logic [31:0] lastOut;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      int          lat;
      logic [31:0] expOut;
   } vec_t;

   vec_t vecs[17];

   cache_controller #(
      .WORD_SIZE (32),
      .L1_DELAY  (3),
      .L2_DELAY  (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .addr     (addr),
      .data     (data),
      .data_out (data_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] expVal);
      total++;
      if (data_out !== expVal) begin
         bad++;
         $display("[TB] FAIL %s got=%h exp=%h", name, data_out, expVal);
      end
   endtask

   // Issues one request while the controller sits in IDLE, scrambles the inputs after
   // the sampling edge, and checks data_out one edge before and at the expected completion.
   task automatic applyStimulus(input string name, input logic wr, input logic [31:0] a,
                                input logic [31:0] d, input int lat, input logic [31:0] expVal);
      wr_en = wr;
      addr  = a;
      data  = d;
      @(posedge clk);
      #1;
      wr_en = 1'b1;
      addr  = 32'h0000_00FF;
      data  = 32'hDEAD_BEEF;
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk);
         #1;
         if (k == lat - 1) checkOutput({name, "_early"}, lastOut);
         if (k == lat)     checkOutput(name, expVal);
      end
      lastOut = expVal;
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      lastOut = 32'h0;
      rst     = 1'b0;
      wr_en   = 1'b0;
      addr    = 32'h0;
      data    = 32'h0;

      vecs[0]  = '{1'b0, 32'h0000_0011, 32'h0,          7, 32'h0000_0000};
      vecs[1]  = '{1'b0, 32'h0000_0011, 32'h0,          3, 32'h0000_0000};
      vecs[2]  = '{1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 3, 32'h0000_0000};
      vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,          3, 32'hA5A5_A5A5};
      vecs[4]  = '{1'b1, 32'h0000_0020, 32'h5A5A_5A5A, 3, 32'hA5A5_A5A5};
      vecs[5]  = '{1'b1, 32'h0000_0030, 32'h1234_5678, 3, 32'hA5A5_A5A5};
      vecs[6]  = '{1'b0, 32'h0000_0021, 32'h0,          7, 32'h0000_0000};
      vecs[7]  = '{1'b0, 32'h0000_0030, 32'h0,          3, 32'h1234_5678};
      vecs[8]  = '{1'b1, 32'h0000_0005, 32'h1111_1111, 3, 32'h1234_5678};
      vecs[9]  = '{1'b1, 32'h0000_0015, 32'h2222_2222, 3, 32'h1234_5678};
      vecs[10] = '{1'b0, 32'h0000_0005, 32'h0,          6, 32'h1111_1111};
      vecs[11] = '{1'b0, 32'h0000_0005, 32'h0,          3, 32'h1111_1111};
      vecs[12] = '{1'b1, 32'h0000_0045, 32'h3333_3333, 3, 32'h1111_1111};
      vecs[13] = '{1'b0, 32'h0000_0005, 32'h0,          7, 32'h1111_1111};
      vecs[14] = '{1'b0, 32'h0000_0045, 32'h0,          7, 32'h3333_3333};
      vecs[15] = '{1'b0, 32'h0000_0120, 32'h0,          6, 32'h5A5A_5A5A};
      vecs[16] = '{1'b0, 32'h0000_0015, 32'h0,          6, 32'h2222_2222};

      #1;
      checkOutput("reset_out", 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 17; i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data,
                       vecs[i].lat, vecs[i].expOut);
      end

      // Abort a read that has reached L2_LOOK; reset must clear data_out at once.
      wr_en = 1'b0;
      addr  = 32'h0000_0099;
      data  = 32'h0;
      @(posedge clk);
      #1;
      wr_en = 1'b1;
      addr  = 32'h0000_00FF;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("abort_out", 32'h0);
      @(negedge clk);
      rst     = 1'b1;
      lastOut = 32'h0;
      applyStimulus("post_rst_rd10", 1'b0, 32'h0000_0010, 32'h0, 7, 32'h0);
      applyStimulus("post_rst_wr33", 1'b1, 32'h0000_0033, 32'hCAFE_F00D, 3, 32'h0);
      applyStimulus("post_rst_rd33", 1'b0, 32'h0000_0033, 32'h0, 3, 32'hCAFE_F00D);
      applyStimulus("post_rst_rd11", 1'b0, 32'h0000_0011, 32'h0, 7, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
